// File: rtl/uart_tx_queue_if.sv
// CPU-store and uart transmit handshake bundle for uart_tx_queue.
// The queue attaches as slave; the CPU/uart side drives through master.
interface uart_tx_queue_if #(
    parameter int XLEN = 32
);
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            clr_ovf;
    logic [XLEN-1:0] status;
    logic [7:0]      tx_data;
    logic            tx_data_valid;
    logic            tx_data_ack;
    logic            txe_irq;
    logic            txe_irq_en;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_data_ack, txe_irq_en,
        input  status, tx_data, tx_data_valid, txe_irq
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_data_ack, txe_irq_en,
        output status, tx_data, tx_data_valid, txe_irq
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Transmit FIFO between CPU byte stores and the uart tx handshake.
// Writes never stall: a push into a full queue is dropped and latched in ovf.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int XLEN       = 32
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_queue_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic empty, full, pop, push, drop;
    logic [XLEN-1:0] status_w;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign pop   = bus.tx_data_ack & ~empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push  = bus.wr_en & (~full | pop);
    assign drop  = bus.wr_en & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // Set beats clear when a drop and clr_ovf coincide.
        if (drop)             ovf_d = 1'b1;
        else if (bus.clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    always_comb begin
        status_w       = '0;
        status_w[8:0]  = 9'(count_q);
        status_w[16]   = empty;
        status_w[17]   = full;
        status_w[18]   = ovf_q;
    end

    assign bus.status        = status_w;
    assign bus.tx_data       = mem_q[rd_ptr_q];
    assign bus.tx_data_valid = ~empty;
    assign bus.txe_irq       = empty & bus.txe_irq_en;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a byte scoreboard and status model.
module tb_uart_tx_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic       movf = 1'b0;

    always #5 clk = ~clk;

    uart_tx_queue_if #(.XLEN(32)) bus ();

    uart_tx_queue #(.DEPTH_LOG2(4), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        int n;
        n = exp_q.size();
        return {13'b0, movf, (n == 16), (n == 0), 7'b0, 9'(n)};
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_status"}, bus.status, model_status());
        chk({tag, "_valid"}, 32'(bus.tx_data_valid), 32'(exp_q.size() != 0));
        chk({tag, "_irq"}, 32'(bus.txe_irq), 32'((exp_q.size() == 0) && bus.txe_irq_en));
        if (exp_q.size() != 0) chk({tag, "_head"}, 32'(bus.tx_data), 32'(exp_q[0]));
    endtask

    // One clock with the given inputs; scoreboard updated alongside.
    task automatic cycle(input logic w, input logic [7:0] d, input logic a, input logic c);
        logic was_full, p;
        bus.wr_en = w; bus.wr_data = d; bus.tx_data_ack = a; bus.clr_ovf = c;
        was_full = (exp_q.size() == 16);
        p = a && (exp_q.size() != 0);
        if (p) begin
            chk("pop_byte", 32'(bus.tx_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (w && (!was_full || p)) exp_q.push_back(d);
        if (w && was_full && !p) movf = 1'b1;
        else if (c) movf = 1'b0;
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.tx_data_ack = 1'b0; bus.clr_ovf = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE; bus.tx_data_ack = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b0; bus.wr_en = 1'b0; bus.tx_data_ack = 1'b0;
        exp_q.delete();
        movf = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.clr_ovf = 1'b0;
        bus.tx_data_ack = 1'b0; bus.txe_irq_en = 1'b1;
        @(posedge clk); #1;

        // Reset with wr_en held high
        do_reset(2);
        chk("rst_status", bus.status, 32'h0001_0000);
        chk("rst_valid", 32'(bus.tx_data_valid), 32'd0);
        chk("rst_irq_en1", 32'(bus.txe_irq), 32'd1);
        bus.txe_irq_en = 1'b0; #1;
        chk("rst_irq_en0", 32'(bus.txe_irq), 32'd0);
        bus.txe_irq_en = 1'b1; #1;

        // Single byte
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        chk("single_valid", 32'(bus.tx_data_valid), 32'd1);
        chk("single_data", 32'(bus.tx_data), 32'h41);
        chk("single_status", bus.status, 32'h0000_0001);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_drained", bus.status, 32'h0001_0000);
        check_state("single");

        // Fill 0x00..0x0F, then drain one ack every 3 cycles
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_status", bus.status, 32'h0002_0010);
        for (int i = 0; i < 16; i++) begin
            chk("order_head", 32'(bus.tx_data), 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check_state("drain16");

        // 20 bytes across the pointer wrap with acks every other cycle
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'h80 + 8'(i), (i % 2) == 1, 1'b0);
            check_state("wrap_push");
        end
        while (exp_q.size() != 0) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check_state("wrap_drain");
        end

        // Overflow: drop, clear, drop-with-clear
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_status", bus.status, 32'h0006_0010);
        check_state("ovf");
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", bus.status, 32'h0002_0010);
        cycle(1'b1, 8'hAB, 1'b0, 1'b1);
        chk("ovf_set_wins", bus.status, 32'h0006_0010);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_state("ovf_clr2");

        // Full queue with push and ack in the same cycle
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("simul_count", bus.status, 32'h0002_0010);
        chk("simul_head", 32'(bus.tx_data), 32'hB1);
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("simul_last", 32'(bus.tx_data), 32'h55);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("simul_done");

        // Spurious ack while empty
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("spurious", bus.status, 32'h0001_0000);

        // Reset mid-stream with 5 bytes held and ovf set
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hCC, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst", bus.status, 32'h0004_0005);
        bus.tx_data_ack = 1'b0;
        do_reset(1);
        chk("mid_rst_status", bus.status, 32'h0001_0000);
        chk("mid_rst_valid", 32'(bus.tx_data_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk("no_stale", 32'(bus.tx_data_valid), 32'd0);
        end
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        check_state("post_rst_push");
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
